gemm_tile_sched: RTL and testbench

GEMM_TILE_SCHED -- requirements
Module: gemm_tile_sched

---
 rtl/gemm_tile_sched.sv | 216 +++++++++++++++++++++
 tb/tb_gemm_tile_sched.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched
// ---------------
// Job scheduler for a tiled matrix multiply. A start pulse captures the
// row-tile count M and the column-tile count N. The block then walks every
// tile in row-major order: (0,0), (0,1) .. (0,N-1), (1,0) .. (M-1,N-1).
// For each tile it runs the same sequence:
//   1. request the operand fetch and wait for the acknowledge (FETCH);
//   2. pulse mm_load to the multiplier (LOAD);
//   3. turn each multiplier row-complete pulse into a result-row write
//      strobe, until the tile-complete pulse arrives (RUN).
// After the last tile it pulses done for one cycle (FIN).
//
// Optional feature (macro SCHED_WATCHDOG_EN):
//   When the macro is defined, RUN aborts the job if WDOG_CYCLES cycles
//   pass with no row-complete pulse. The abort pulses err and goes straight
//   to IDLE, with no done pulse. When the macro is undefined, err is tied
//   to 0 and RUN waits indefinitely.
//
// Parameters
//   S2P_SIZE     rows per tile (power of two, >= 2)
//   IDX_W        width of tile counts and tile indices
//   WDOG_CYCLES  idle cycles allowed in RUN before abort (watchdog only)
//
// Ports
//   clk, rstn                     clock; asynchronous active-low reset
//   start, cfg_m_tiles,
//   cfg_n_tiles                   job start pulse and tile counts
//   fetch_req/fetch_ack,
//   fetch_m_idx/fetch_n_idx       operand tile fetch handshake and address
//   mm_load                       one-cycle load pulse to the multiplier
//   mm_row_done, mm_tile_done     multiplier progress pulses
//   out_valid, out_row,
//   out_m_idx, out_n_idx          result-row write strobe and its address
//   busy, done, err               job active, job complete, watchdog abort
`timescale 1ns/1ps
module gemm_tile_sched #(
    parameter int S2P_SIZE    = 4,
    parameter int IDX_W       = 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [IDX_W-1:0]            cfg_m_tiles,
    input  logic [IDX_W-1:0]            cfg_n_tiles,
    output logic                        fetch_req,
    input  logic                        fetch_ack,
    output logic [IDX_W-1:0]            fetch_m_idx,
    output logic [IDX_W-1:0]            fetch_n_idx,
    output logic                        mm_load,
    input  logic                        mm_row_done,
    input  logic                        mm_tile_done,
    output logic                        out_valid,
    output logic [$clog2(S2P_SIZE)-1:0] out_row,
    output logic [IDX_W-1:0]            out_m_idx,
    output logic [IDX_W-1:0]            out_n_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int                  ROW_W   = $clog2(S2P_SIZE);
    localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);
    localparam logic [ROW_W-1:0]    ROW_ONE = ROW_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [IDX_W-1:0]   r_m_cfg;
    logic [IDX_W-1:0]   r_n_cfg;
    logic [IDX_W-1:0]   r_m_idx;
    logic [IDX_W-1:0]   r_n_idx;
    logic [ROW_W-1:0]   r_row;

    logic               w_start_job;
    logic               w_last_tile;
    logic               w_last_col;
    logic               w_wdog_hit;
    logic               w_err;

    // Only an idle scheduler accepts a start; a start while busy is dropped.
    assign w_start_job = (r_state == IDLE) && start;
    assign w_last_col  = (r_n_idx == (r_n_cfg - IDX_ONE));
    assign w_last_tile = (r_m_idx == (r_m_cfg - IDX_ONE)) && w_last_col;

`ifdef SCHED_WATCHDOG_EN
    logic [31:0] r_wdog;

    // Counts RUN cycles since entering RUN or since the last row pulse. It
    // is held at zero outside RUN, so the first RUN cycle always sees 0 and
    // the abort lands on the WDOG_CYCLES-th quiet RUN cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
        end else if ((r_state != RUN) || mm_row_done) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    assign w_wdog_hit = (r_state == RUN) && !mm_row_done &&
                        (r_wdog == 32'(WDOG_CYCLES - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        w_state_next = r_state;
        fetch_req    = 1'b0;
        mm_load      = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // An empty job completes without touching memory.
                    if ((cfg_m_tiles == '0) || (cfg_n_tiles == '0)) begin
                        w_state_next = FIN;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                mm_load      = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                out_valid = mm_row_done;
                // Tile completion has priority over the watchdog: a tile
                // that finishes on the abort cycle still counts as done.
                if (mm_tile_done) begin
                    w_state_next = w_last_tile ? FIN : FETCH;
                end else if (w_wdog_hit) begin
                    w_err        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            FIN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Job configuration, tile walk and row counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_cfg <= '0;
            r_n_cfg <= '0;
            r_m_idx <= '0;
            r_n_idx <= '0;
            r_row   <= '0;
        end else if (w_start_job) begin
            r_m_cfg <= cfg_m_tiles;
            r_n_cfg <= cfg_n_tiles;
            r_m_idx <= '0;
            r_n_idx <= '0;
            r_row   <= '0;
        end else if (r_state == RUN) begin
            if (mm_tile_done) begin
                r_row <= '0;
                // Indices stay on the final tile once the job is complete.
                if (!w_last_tile) begin
                    if (w_last_col) begin
                        r_n_idx <= '0;
                        r_m_idx <= r_m_idx + IDX_ONE;
                    end else begin
                        r_n_idx <= r_n_idx + IDX_ONE;
                    end
                end
            end else if (mm_row_done) begin
                // Natural wrap: S2P_SIZE is a power of two.
                r_row <= r_row + ROW_ONE;
            end
        end
    end

    assign fetch_m_idx = r_m_idx;
    assign fetch_n_idx = r_n_idx;
    assign out_row     = r_row;
    assign out_m_idx   = r_m_idx;
    assign out_n_idx   = r_n_idx;
    assign busy        = (r_state != IDLE);
    assign err         = w_err;

endmodule

// File: tb/tb_gemm_tile_sched.sv
`timescale 1ns/1ps
module tb_gemm_tile_sched;

    localparam int S2P = 4;
    localparam int IW  = 8;
    localparam int RW  = 2;
    localparam int WD  = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] cfg_m = '0;
    logic [IW-1:0] cfg_n = '0;
    logic          fetch_req;
    logic          fetch_ack;
    logic [IW-1:0] fetch_m_idx;
    logic [IW-1:0] fetch_n_idx;
    logic          mm_load;
    logic          mm_row_done;
    logic          mm_tile_done;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic [IW-1:0] out_m_idx;
    logic [IW-1:0] out_n_idx;
    logic          busy;
    logic          done;
    logic          err;

    // Responder controls and model outputs
    logic ack_en = 1'b0;
    logic ack_man = 1'b0;
    logic mdl_ack = 1'b0;
    logic mm_en = 1'b1;
    logic spur_row = 1'b0;
    logic mdl_row = 1'b0;
    logic mdl_tile = 1'b0;
    int   ack_cnt = 0;
    int   mm_phase = 0;

    assign fetch_ack    = mdl_ack | ack_man;
    assign mm_row_done  = mdl_row | spur_row;
    assign mm_tile_done = mdl_tile;

    int checks = 0;
    int failures = 0;

    // Monitor state (written only by the monitor process)
    int                  cyc = 0;
    logic [2*IW-1:0]     fetch_log[$];
    logic [RW+2*IW-1:0]  ov_log[$];
    int                  done_cnt = 0;
    int                  err_cnt = 0;
    int                  busy_cnt = 0;
    int                  load_cnt = 0;
    int                  lat_bad = 0;
    int                  done_cyc = 0;
    int                  err_cyc = 0;
    int                  start_cyc = 0;
    int                  load_cyc = 0;
    logic                prev_req = 1'b0;
    logic                prev_ack = 1'b0;

    gemm_tile_sched #(
        .S2P_SIZE    (S2P),
        .IDX_W       (IW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_m_tiles  (cfg_m),
        .cfg_n_tiles  (cfg_n),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .fetch_m_idx  (fetch_m_idx),
        .fetch_n_idx  (fetch_n_idx),
        .mm_load      (mm_load),
        .mm_row_done  (mm_row_done),
        .mm_tile_done (mm_tile_done),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_m_idx    (out_m_idx),
        .out_n_idx    (out_n_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Fetch responder: acknowledge in the third cycle of a request.
    initial forever begin
        @(posedge clk);
        #1;
        if (ack_en && fetch_req) begin
            ack_cnt = ack_cnt + 1;
            mdl_ack = (ack_cnt >= 3);
        end else begin
            ack_cnt = 0;
            mdl_ack = 1'b0;
        end
    end

    // Multiplier model: S2P row pulses after mm_load, then a tile pulse.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            mm_phase = 0; mdl_row = 1'b0; mdl_tile = 1'b0;
        end else if (mm_load && mm_en) begin
            mm_phase = 1; mdl_row = 1'b0; mdl_tile = 1'b0;
        end else if (mm_phase >= 1 && mm_phase <= S2P) begin
            mdl_row = 1'b1; mdl_tile = 1'b0; mm_phase = mm_phase + 1;
        end else if (mm_phase == S2P + 1) begin
            mdl_row = 1'b0; mdl_tile = 1'b1; mm_phase = mm_phase + 1;
        end else begin
            mdl_row = 1'b0; mdl_tile = 1'b0; mm_phase = 0;
        end
    end

    // Monitor: samples on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc = cyc + 1;
        if (fetch_req && !prev_req) fetch_log.push_back({fetch_m_idx, fetch_n_idx});
        prev_req = fetch_req;
        if (out_valid) ov_log.push_back({out_row, out_m_idx, out_n_idx});
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (err) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
        if (busy) busy_cnt = busy_cnt + 1;
        if (start) start_cyc = cyc;
        if (mm_load) begin
            load_cnt = load_cnt + 1;
            load_cyc = cyc;
            if (!prev_ack) lat_bad = lat_bad + 1;
        end
        prev_ack = fetch_req && fetch_ack;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic pulse_start(input int m, input int n);
        @(posedge clk);
        #1;
        cfg_m = IW'(m);
        cfg_n = IW'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_m = 8'h77;   // junk: must not be picked up after the start
        cfg_n = 8'h77;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [60:0] outs;
        rstn = 1'b0;
        #12;
        outs = {fetch_req, fetch_m_idx, fetch_n_idx, mm_load, out_valid, out_row,
                out_m_idx, out_n_idx, busy, done, err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0", outs);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy actual=%b required=0", busy);
        end
        $display("test_reset: done");
    endtask

    task automatic test_full_job;
        int f0 = fetch_log.size();
        int o0 = ov_log.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int lb0 = lat_bad;
        int ld0 = load_cnt;
        int bad;
        int k;
        bit ok;
        logic [2*IW-1:0] fexp;
        logic [RW+2*IW-1:0] oexp;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        cfg_m = 8'd2; cfg_n = 8'd3; start = 1'b1;
        @(negedge clk);
        checks++;
        if (fetch_req !== 1'b0) begin
            failures++;
            $display("FAIL start_latency_early fetch_req actual=%b required=0", fetch_req);
        end
        @(posedge clk);
        #1;
        start = 1'b0; cfg_m = 8'h77; cfg_n = 8'h77;
        @(negedge clk);
        checks++;
        if ({fetch_req, busy, fetch_m_idx, fetch_n_idx} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL start_latency req/busy/m/n actual=%b/%b/%0d/%0d required=1/1/0/0",
                     fetch_req, busy, fetch_m_idx, fetch_n_idx);
        end
        wait_done(600, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL full_job_done_timeout actual=no_done required=done");
        end
        checks++;
        if (fetch_log.size() - f0 !== 6) begin
            failures++;
            $display("FAIL full_job_fetch_count actual=%0d required=6", fetch_log.size() - f0);
        end else begin
            k = 0;
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 3; n++) begin
                    fexp = {IW'(m), IW'(n)};
                    checks++;
                    if (fetch_log[f0 + k] !== fexp) begin
                        failures++;
                        $display("FAIL fetch_order[%0d] actual=%h required=%h", k, fetch_log[f0 + k], fexp);
                    end
                    k++;
                end
            end
        end
        checks++;
        if (ov_log.size() - o0 !== 24) begin
            failures++;
            $display("FAIL full_job_out_valid_count actual=%0d required=24", ov_log.size() - o0);
        end else begin
            bad = 0;
            for (int i = 0; i < 24; i++) begin
                oexp = {RW'(i % 4), IW'(i / 12), IW'((i / 4) % 3)};
                if (ov_log[o0 + i] !== oexp) bad++;
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL full_job_row_addresses bad_entries actual=%0d required=0", bad);
            end
        end
        checks++;
        if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin
            failures++;
            $display("FAIL full_job_done/err pulses actual=%0d/%0d required=1/0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if ({load_cnt - ld0, lat_bad - lb0} !== {32'd6, 32'd0}) begin
            failures++;
            $display("FAIL full_job_loads/late_loads actual=%0d/%0d required=6/0", load_cnt - ld0, lat_bad - lb0);
        end
        $display("test_full_job: fetches=%0d rows=%0d", fetch_log.size() - f0, ov_log.size() - o0);
    endtask

    task automatic test_zero_tiles;
        int f0 = fetch_log.size();
        int d0 = done_cnt;
        int b0 = busy_cnt;
        int ld0 = load_cnt;
        pulse_start(0, 5);
        repeat (6) @(negedge clk);
        checks++;
        if (fetch_log.size() - f0 !== 0 || load_cnt - ld0 !== 0) begin
            failures++;
            $display("FAIL zero_job_fetches actual=%0d required=0", fetch_log.size() - f0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL zero_job_done_count actual=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (busy_cnt - b0 !== 1) begin
            failures++;
            $display("FAIL zero_job_busy_cycles actual=%0d required=1", busy_cnt - b0);
        end
        checks++;
        if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
            failures++;
            $display("FAIL zero_job_done_latency actual=%0d required=1..2", done_cyc - start_cyc);
        end
        $display("test_zero_tiles: done_latency=%0d", done_cyc - start_cyc);
    endtask

    task automatic test_start_during_job;
        int f0 = fetch_log.size();
        int o0 = ov_log.size();
        int d0 = done_cnt;
        bit ok;
        logic [2*IW-1:0] f1;
        ack_en = 1'b1;
        pulse_start(1, 2);
        pulse_start(3, 3);          // lands in FETCH of the first tile
        repeat (6) @(posedge clk);
        pulse_start(3, 3);          // lands later in the job
        wait_done(400, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL restart_done_timeout actual=no_done required=done");
        end
        checks++;
        if (fetch_log.size() - f0 !== 2) begin
            failures++;
            $display("FAIL restart_fetch_count actual=%0d required=2", fetch_log.size() - f0);
        end else begin
            f1 = fetch_log[f0 + 1];
            checks++;
            if (f1 !== {8'd0, 8'd1}) begin
                failures++;
                $display("FAIL restart_second_tile actual=%h required=0001", f1);
            end
        end
        checks++;
        if ({ov_log.size() - o0, done_cnt - d0} !== {32'd8, 32'd1}) begin
            failures++;
            $display("FAIL restart_rows/done actual=%0d/%0d required=8/1", ov_log.size() - o0, done_cnt - d0);
        end
        $display("test_start_during_job: fetches=%0d", fetch_log.size() - f0);
    endtask

    task automatic test_reset_mid_run;
        bit found = 1'b0;
        bit ok;
        int f0, o0, d0, bad;
        logic [60:0] outs;
        ack_en = 1'b1;
        pulse_start(2, 2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid && out_m_idx == 8'd0 && out_n_idx == 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_reach_tile01 actual=not_seen required=seen");
        end
        #2;
        rstn = 1'b0;
        #1;
        outs = {fetch_req, fetch_m_idx, fetch_n_idx, mm_load, out_valid, out_row,
                out_m_idx, out_n_idx, busy, done, err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL mid_run_reset_outputs actual=%h required=0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        f0 = fetch_log.size();
        o0 = ov_log.size();
        d0 = done_cnt;
        pulse_start(1, 1);
        wait_done(200, ok);
        checks++;
        if (ok !== 1'b1 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL post_reset_done actual=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (fetch_log.size() - f0 !== 1 || ov_log.size() - o0 !== 4) begin
            failures++;
            $display("FAIL post_reset_fetch/rows actual=%0d/%0d required=1/4",
                     fetch_log.size() - f0, ov_log.size() - o0);
        end else begin
            bad = 0;
            if (fetch_log[f0] !== '0) bad++;
            for (int i = 0; i < 4; i++) if (ov_log[o0 + i] !== {RW'(i), 16'd0}) bad++;
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL post_reset_addresses bad_entries actual=%0d required=0", bad);
            end
        end
        $display("test_reset_mid_run: post-reset rows=%0d", ov_log.size() - o0);
    endtask

    task automatic test_spurious_row;
        int o0;
        int bad = 0;
        bit ok;
        ack_en = 1'b0;
        pulse_start(1, 1);
        o0 = ov_log.size();
        spur_row = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({fetch_req, out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL spurious_row_cycle%0d req/out_valid actual=%b/%b required=1/0",
                         i, fetch_req, out_valid);
            end
        end
        @(posedge clk);
        #1;
        spur_row = 1'b0;
        ack_man = 1'b1;
        @(posedge clk);
        #1;
        ack_man = 1'b0;
        wait_done(200, ok);
        checks++;
        if (ok !== 1'b1 || ov_log.size() - o0 !== 4) begin
            failures++;
            $display("FAIL spurious_job_rows actual=%0d required=4", ov_log.size() - o0);
        end else begin
            for (int i = 0; i < 4; i++) if (ov_log[o0 + i] !== {RW'(i), 16'd0}) bad++;
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL spurious_row_counter bad_entries actual=%0d required=0", bad);
            end
        end
        ack_en = 1'b1;
        $display("test_spurious_row: rows=%0d", ov_log.size() - o0);
    endtask

`ifdef SCHED_WATCHDOG_EN
    task automatic test_watchdog;
        int d0 = done_cnt;
        int e0 = err_cnt;
        ack_en = 1'b1;
        mm_en = 1'b0;
        pulse_start(1, 1);
        repeat (40) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL watchdog_err/done actual=%0d/%0d required=1/0", err_cnt - e0, done_cnt - d0);
        end
        checks++;
        if (err_cyc - load_cyc !== WD) begin
            failures++;
            $display("FAIL watchdog_timing actual=%0d required=%0d", err_cyc - load_cyc, WD);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_idle busy actual=%b required=0", busy);
        end
        mm_en = 1'b1;
        $display("test_watchdog: err_after_load=%0d", err_cyc - load_cyc);
    endtask
`endif

    initial begin
        test_reset();
        test_full_job();
        test_zero_tiles();
        test_start_during_job();
        test_reset_mid_run();
        test_spurious_row();
`ifdef SCHED_WATCHDOG_EN
        test_watchdog();
`else
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt !== 0) begin
            failures++;
            $display("FAIL err_tied_low pulses actual=%0d required=0", err_cnt);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
